// File: rtl/dr_bit_loader.sv
// Collects dual-rail addressed single-bit writes into an 8-bit word and hands the
// word downstream over valid/ready; rejects bad codes and discards stale partial words.
module dr_bit_loader #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       grp,
  input  logic       row_p,
  input  logic       row_n,
  input  logic       col_p,
  input  logic       col_n,
  input  logic       en_a,
  input  logic       en_b,
  input  logic       din,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_word,
  output logic       err_code,
  output logic       timeout,
  output logic       dup
);

  typedef enum logic {S_FILL, S_FULL} state_e;

  state_e           state_q, state_d;
  logic [7:0]       word_q, word_d;
  logic [7:0]       mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             tout_q, tout_d;
  logic             dup_q, dup_d;

  logic       accept, code_ok, wr, drain, wd_fire;
  logic [2:0] idx;
  logic [7:0] sel, mask_set;

  always_comb begin
    accept   = in_valid & in_ready;
    code_ok  = (row_p ^ row_n) & (col_p ^ col_n) & (en_a ^ en_b);
    wr       = accept & code_ok;
    idx      = {grp, row_p, col_p};
    sel      = 8'(1) << idx;
    mask_set = mask_q | sel;
    drain    = out_valid & out_ready;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FILL;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FILL: if (wr && (mask_set == '1)) state_d = S_FULL;
      S_FULL: if (out_ready)              state_d = S_FILL;
      default:                            state_d = S_FILL;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state_q == S_FILL);
    out_valid = (state_q == S_FULL);
  end

  // Any accept clears the watchdog, so an accept on the expiry cycle always wins.
  always_comb begin
    word_d  = word_q;
    mask_d  = mask_q;
    cnt_d   = '0;
    wd_fire = 1'b0;
    if (wr) word_d[idx] = din;
    if (drain) begin
      mask_d = '0;
    end else if (wr) begin
      mask_d = mask_set;
    end else if ((state_q == S_FILL) && !accept && (mask_q != '0) && (TIMEOUT != 0)) begin
      if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
        wd_fire = 1'b1;
        mask_d  = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    err_d  = accept & ~code_ok;
    dup_d  = wr & (|(mask_q & sel));
    tout_d = wd_fire;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      mask_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      tout_q <= 1'b0;
      dup_q  <= 1'b0;
    end else begin
      word_q <= word_d;
      mask_q <= mask_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      tout_q <= tout_d;
      dup_q  <= dup_d;
    end
  end

  assign out_word = word_q;
  assign err_code = err_q;
  assign timeout  = tout_q;
  assign dup      = dup_q;

endmodule

// File: tb/tb_dr_bit_loader.sv
// Directed bench for dr_bit_loader: table-driven write vectors plus hand-written
// sequences for backpressure, watchdog and asynchronous reset.
module tb_dr_bit_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic       grp, row_p, row_n, col_p, col_n, en_a, en_b, din;
  logic       out_valid, out_ready;
  logic [7:0] out_word;
  logic       err_code, timeout, dup;

  int errors = 0;
  int checks = 0;
  int n_err  = 0;
  int n_dup  = 0;
  int n_tout = 0;

  dr_bit_loader #(.TIMEOUT(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .grp(grp), .row_p(row_p), .row_n(row_n), .col_p(col_p), .col_n(col_n),
    .en_a(en_a), .en_b(en_b), .din(din),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .err_code(err_code), .timeout(timeout), .dup(dup)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      n_err  += int'(err_code);
      n_dup  += int'(dup);
      n_tout += int'(timeout);
    end
  end

  typedef struct {
    logic [2:0] idx;
    logic       d;
    int         kind;   // 0 valid, 1 row rails 11, 2 col rails 00, 3 enable 11
    logic       e_err;
    logic       e_dup;
    logic       e_ov;
    logic [7:0] e_word;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [2:0] idx, input logic d, input int kind,
                              input logic e_err, input logic e_dup, input logic e_ov,
                              input logic [7:0] e_word);
    vec_t v;
    v.idx = idx; v.d = d; v.kind = kind;
    v.e_err = e_err; v.e_dup = e_dup; v.e_ov = e_ov; v.e_word = e_word;
    return v;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkn(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [2:0] idx, input logic d, input int kind);
    grp = idx[2];
    row_p = idx[1]; row_n = ~idx[1];
    col_p = idx[0]; col_n = ~idx[0];
    en_a = ~idx[1]; en_b = idx[1];
    din = d;
    case (kind)
      1: begin row_p = 1'b1; row_n = 1'b1; end
      2: begin col_p = 1'b0; col_n = 1'b0; end
      3: begin en_a = 1'b1; en_b = 1'b1; end
      default: ;
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [2:0] idx, input logic d);
    drive(idx, d, 0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk1({nm, "_drain_out_valid"}, out_valid, 1'b0);
    chk1({nm, "_drain_in_ready"}, in_ready, 1'b1);
  endtask

  task automatic do_reset(input string nm);
    #2 rst_n = 1'b0;
    #1;
    chk1({nm, "_rst_out_valid"}, out_valid, 1'b0);
    chk1({nm, "_rst_in_ready"}, in_ready, 1'b1);
    chk8({nm, "_rst_word"}, out_word, 8'h00);
    chk1({nm, "_rst_flags"}, err_code | dup | timeout, 1'b0);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [7:0] w;
    vec_t v;
    int e0, d0, t0;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    grp = 0; row_p = 0; row_n = 0; col_p = 0; col_n = 0; en_a = 0; en_b = 0; din = 0;

    // Sequential fill -> 8'hAA
    w = 8'hAA;
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(3'(i), w[i], 0, 1'b0, 1'b0, i == 7, w));
    // Three invalid codes, then 8'h66 written high index first
    tbl.push_back(mk(3'd5, 1'b1, 1, 1'b1, 1'b0, 1'b0, 8'h00));
    tbl.push_back(mk(3'd2, 1'b1, 2, 1'b1, 1'b0, 1'b0, 8'h00));
    tbl.push_back(mk(3'd7, 1'b1, 3, 1'b1, 1'b0, 1'b0, 8'h00));
    w = 8'h66;
    for (int i = 7; i >= 0; i--)
      tbl.push_back(mk(3'(i), w[i], 0, 1'b0, 1'b0, i == 0, w));
    // Duplicate write on index 3, last write wins -> 8'hF7
    tbl.push_back(mk(3'd3, 1'b1, 0, 1'b0, 1'b0, 1'b0, 8'h00));
    tbl.push_back(mk(3'd3, 1'b0, 0, 1'b0, 1'b1, 1'b0, 8'h00));
    for (int i = 0; i < 8; i++)
      if (i != 3) tbl.push_back(mk(3'(i), 1'b1, 0, 1'b0, 1'b0, i == 7, 8'hF7));

    #12;
    chk1("reset_in_ready", in_ready, 1'b1);
    chk1("reset_out_valid", out_valid, 1'b0);
    chk8("reset_word", out_word, 8'h00);
    chk1("reset_err", err_code, 1'b0);
    chk1("reset_dup", dup, 1'b0);
    chk1("reset_timeout", timeout, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      drive(v.idx, v.d, v.kind);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk1($sformatf("vec%0d_err", i), err_code, v.e_err);
      chk1($sformatf("vec%0d_dup", i), dup, v.e_dup);
      chk1($sformatf("vec%0d_out_valid", i), out_valid, v.e_ov);
      chk1($sformatf("vec%0d_in_ready", i), in_ready, ~v.e_ov);
      chk1($sformatf("vec%0d_timeout", i), timeout, 1'b0);
      if (v.e_ov) begin
        chk8($sformatf("vec%0d_word", i), out_word, v.e_word);
        drain($sformatf("vec%0d", i));
      end
    end

    // Backpressure: word held while in_valid stays high
    e0 = n_err; d0 = n_dup;
    w = 8'h5C;
    for (int i = 0; i < 8; i++) write(3'(i), w[i]);
    chk1("bp_out_valid", out_valid, 1'b1);
    chk8("bp_word", out_word, 8'h5C);
    drive(3'd0, 1'b1, 0);
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      chk1($sformatf("bp_hold%0d_in_ready", c), in_ready, 1'b0);
      chk1($sformatf("bp_hold%0d_out_valid", c), out_valid, 1'b1);
      chk8($sformatf("bp_hold%0d_word", c), out_word, 8'h5C);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk1("bp_hs_out_valid", out_valid, 1'b0);
    chk1("bp_hs_in_ready", in_ready, 1'b1);
    step(); step();
    chk1("bp_no_second_word", out_valid, 1'b0);
    chkn("bp_err_pulses", n_err - e0, 0);
    chkn("bp_dup_pulses", n_dup - d0, 0);

    // Watchdog expiry after 4 idle cycles
    d0 = n_dup;
    write(3'd0, 1'b1);
    write(3'd1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      step();
      chk1($sformatf("wd_idle%0d_timeout", c), timeout, 1'b0);
    end
    step();
    chk1("wd_fire", timeout, 1'b1);
    step();
    chk1("wd_single_pulse", timeout, 1'b0);
    w = 8'h0C;
    for (int i = 0; i < 8; i++) begin
      write(3'(i), w[i]);
      chk1($sformatf("wd_new%0d_out_valid", i), out_valid, i == 7);
    end
    chk8("wd_new_word", out_word, 8'h0C);
    chkn("wd_new_no_dup", n_dup - d0, 0);
    drain("wd");

    // 3-cycle idle gap then accept: no expiry
    t0 = n_tout;
    w = 8'hE1;
    write(3'd0, w[0]);
    step(); step(); step();
    for (int i = 1; i < 8; i++) write(3'(i), w[i]);
    chkn("gap_no_timeout", n_tout - t0, 0);
    chk1("gap_out_valid", out_valid, 1'b1);
    chk8("gap_word", out_word, 8'hE1);
    drain("gap");

    // Asynchronous reset while FULL
    for (int i = 0; i < 8; i++) write(3'(i), 1'b1);
    chk1("rf_full", out_valid, 1'b1);
    do_reset("rf");

    // Asynchronous reset mid-fill, then a full 8 writes are required
    for (int i = 0; i < 5; i++) write(3'(i), 1'b1);
    do_reset("rm");
    d0 = n_dup;
    w = 8'h3A;
    for (int i = 0; i < 7; i++) write(3'(i), w[i]);
    chk1("rm_seven_not_full", out_valid, 1'b0);
    write(3'd7, w[7]);
    chk1("rm_eight_full", out_valid, 1'b1);
    chk8("rm_word", out_word, 8'h3A);
    chkn("rm_no_dup", n_dup - d0, 0);
    drain("rm");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dr_bit_loader.md
# dr_bit_loader

Write-side companion to the dual-rail 1-of-8 bit selector in the autosymmetry benchmark set. It accepts single-bit writes, each addressed by a group bit plus dual-rail row and column pairs and qualified by a dual-rail enable pair. It assembles the bits into an 8-bit word and hands the word downstream over a valid/ready handshake. Invalid dual-rail codes are rejected and flagged. A watchdog discards words that are stuck partially filled.

## Interface
- TIMEOUT, default 64: idle cycles in FILL with a non-empty mask before the partial word is discarded; 0 disables the watchdog.
- CNT_W, default 7: watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  write request.
- in_ready  output  1  block can accept a write.
- grp  input  1  address bit 2 (high half / low half).
- row_p, row_n  input  1 each  dual-rail address bit 1; valid codes 10 → 1, 01 → 0.
- col_p, col_n  input  1 each  dual-rail address bit 0; valid codes 10 → 1, 01 → 0.
- en_a, en_b  input  1 each  dual-rail enable; write permitted only when en_a ^ en_b = 1.
- din  input  1  data bit.
- out_valid  output  1  assembled word available.
- out_ready  input  1  downstream accepts the word.
- out_word  output  8  assembled word; bit index = {grp, row, col}.
- err_code  output  1  one-cycle pulse: an accepted write had an invalid code.
- timeout  output  1  one-cycle pulse: a partial word was discarded.
- dup  output  1  one-cycle pulse: a write landed on an already-written index.

## Operation
- There are two states.
  - FILL: in_ready=1, out_valid=0.
  - FULL: in_ready=0, out_valid=1.
- Accept condition: in_valid & in_ready.
- On accept, the code is valid iff (row_p ^ row_n) & (col_p ^ col_n) & (en_a ^ en_b).
  - Invalid code: no write, mask unchanged, err_code pulses on the next cycle.
  - Valid code: word[idx] ← din and mask[idx] ← 1, with idx = {grp, row_p, col_p}.
  - If mask[idx] was already 1, dup pulses and the bit is overwritten (last write wins).
- FILL → FULL in the cycle in which a valid accept makes the mask 8'hFF.
- FULL → FILL on out_valid & out_ready. In the same edge, mask clears to 0, the watchdog clears to 0, and word is retained but don't-care.
- Watchdog:
  - While in FILL with mask ≠ 0 and no accept, the counter increments.
  - Any accept, valid or invalid, resets the counter to 0.
  - When the counter reaches TIMEOUT: mask ← 0, counter ← 0, timeout pulses. The state stays FILL.
  - The counter is held at 0 when the mask is 0 or the state is FULL.
- Watchdog expiry and an accept in the same cycle: the accept wins and the counter resets.
- out_word is driven directly from the word register. It is stable for the whole time out_valid=1.

## Timing
- Reset values: state FILL, in_ready=1, out_valid=0, out_word=8'h00, mask=0, counter=0, err_code=0, timeout=0, dup=0.
- Reset is asynchronous and may assert mid-word or in FULL. Any pending word is lost, and there is no output pulse on reset.
- Latency: out_valid rises on the first edge after the 8th distinct valid accept.
- Minimum word time: 8 accept cycles + 1 drain cycle.
- in_ready falls in the same cycle that out_valid rises. It returns one cycle after the out handshake; there is no combinational path from out_ready to in_ready.
- All flags are registered single-cycle pulses. At most one of err_code and dup fires per accept.
- in_valid held high while in_ready=0: no effect. The inputs are sampled only on accept.
- out_valid is never withdrawn without out_ready. The block ignores out_ready while in FILL.

## Test plan
- Sequential fill: write din=idx[0] to idx 0..7 with valid codes and out_ready=1. Required: out_valid=1 one cycle after the 8th accept, out_word=8'hAA, handshake completes, in_ready=1 on the following cycle.
- Invalid codes: on accept, apply row_p=row_n=1, then col_p=col_n=0, then en_a=en_b=1. Required: 3 err_code pulses and mask unchanged; 8 valid writes afterward still produce a correct word.
- Duplicate write: write idx 3 with din=1, then idx 3 with din=0, then the remaining 7 indices with din=1. Required: one dup pulse and out_word=8'hF7.
- Backpressure: fill 8'h5C with out_ready=0 for 10 cycles while in_valid stays high. Required: in_ready=0, out_word holds 8'h5C, no extra writes; raising out_ready completes exactly one word.
- Watchdog with TIMEOUT=4: write idx 0 and 1, then idle. Required: timeout pulses after 4 idle cycles, the mask clears, and 8 new writes produce only the new data. A 3-cycle idle gap followed by an accept must not time out.
- Asynchronous reset in FULL and mid-fill (after 5 writes). Required: out_valid=0, in_ready=1, out_word=8'h00 immediately; the next word needs all 8 writes.
